// File: rtl/if_stage_pkg.sv
// Shared widths, reset vector and branch-buffer state encoding for the fetch stage.
package if_stage_pkg;

    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int BR_BUS_WD       = 33;
    localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;

    typedef enum logic [1:0] {
        BR_IDLE    = 2'd0,
        BR_WAIT_DS = 2'd1,
        BR_READY   = 2'd2
    } br_state_t;

endpackage

// File: rtl/if_br_buf.sv
// Remembers a taken branch from decode until the delay slot and then the target
// have both been accepted by the instruction port.
module if_br_buf
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        fs_valid,
    input  logic        accept,
    output logic        br_idle,
    output logic        br_ready,
    output logic [31:0] br_tgt
);

    br_state_t state;
    br_state_t next_state;
    logic      capture;

    // With fs_valid set the delay slot is already in IF; otherwise it still has to be fetched.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        case (state)
            BR_IDLE: begin
                if (br_taken) begin
                    if (fs_valid && accept) begin
                        next_state = BR_IDLE;
                    end else if (fs_valid || accept) begin
                        next_state = BR_READY;
                        capture    = 1'b1;
                    end else begin
                        next_state = BR_WAIT_DS;
                        capture    = 1'b1;
                    end
                end
            end
            BR_WAIT_DS: begin
                if (accept) next_state = BR_READY;
            end
            BR_READY: begin
                if (accept) next_state = BR_IDLE;
            end
            default: next_state = BR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= BR_IDLE;
            br_tgt <= 32'd0;
        end else begin
            state <= next_state;
            if (capture) br_tgt <= br_target;
        end
    end

    assign br_idle  = (state == BR_IDLE);
    assign br_ready = (state == BR_READY);

endmodule

// File: rtl/if_stage.sv
// MIPS fetch stage: next-PC select, instruction request, IF register and
// a one-entry buffer for instructions that return while decode is stalled.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [3:0]                 inst_sram_wstrb,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
);

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        ibuf_valid;
    logic [31:0] ibuf;
    logic        br_taken;
    logic [31:0] br_target;
    logic        br_idle;
    logic        br_ready;
    logic [31:0] br_tgt;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        accept;
    logic        handoff;
    logic [31:0] fs_inst;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    if_br_buf u_br_buf (
        .clk       (clk),
        .reset     (reset),
        .br_taken  (br_taken),
        .br_target (br_target),
        .fs_valid  (fs_valid),
        .accept    (accept),
        .br_idle   (br_idle),
        .br_ready  (br_ready),
        .br_tgt    (br_tgt)
    );

    assign seq_pc = fs_pc + 32'd4;
    assign nextpc = br_ready                         ? br_tgt    :
                    (br_taken && fs_valid && br_idle) ? br_target : seq_pc;

    assign fs_ready_go = ibuf_valid | (fs_valid & inst_sram_data_ok);
    assign fs_allowin  = !fs_valid | (fs_ready_go & ds_allowin);
    assign handoff     = fs_ready_go & ds_allowin;

    assign inst_sram_req   = !reset & fs_allowin;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'd0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'd0;
    assign accept          = inst_sram_req & inst_sram_addr_ok;

    // A data_ok seen while fs_valid is low belongs to a fetch killed by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid   <= 1'b0;
            fs_pc      <= RESET_PC - 32'd4;
            ibuf_valid <= 1'b0;
            ibuf       <= 32'd0;
        end else begin
            if (accept) begin
                fs_valid <= 1'b1;
                fs_pc    <= nextpc;
            end else if (handoff) begin
                fs_valid <= 1'b0;
            end
            if (handoff) begin
                ibuf_valid <= 1'b0;
            end else if (fs_valid && inst_sram_data_ok && !ds_allowin && !ibuf_valid) begin
                ibuf_valid <= 1'b1;
                ibuf       <= inst_sram_rdata;
            end
        end
    end

    assign fs_inst        = ibuf_valid ? ibuf : inst_sram_rdata;
    assign fs_to_ds_valid = fs_valid & fs_ready_go;
    assign fs_to_ds_bus   = {fs_inst, (fs_valid ? fs_pc : seq_pc)};

endmodule
